frame_stats_sampler: RTL and testbench
======================================

Name: frame_stats_sampler

Overview:
- Upstream feeder for the I2C frame logger, in the camera pixel-clock domain.
- Measures the camera pixel stream once per frame: frame count, line count, line length, luma sum, min/max pixel, and dropped snapshots.
- Once per FRAME_DIV frames it presents one measurement as a single-cycle new_sample strobe with page/value, paced by the logger's busy.
- Pages rotate so every statistic is eventually logged.

Parameters:
- VS_ACTIVE_HIGH, 1, vsync polarity (1 = vsync high during vertical blanking).
- FRAME_DIV, 4, emit one sample per FRAME_DIV completed frames (legal range 1..255).
- LUMA_SHIFT, 16, right shift applied to the 32-bit luma sum for page 3.
- NUM_PAGES, 7, page rotation length (fixed at 7; pages 0..6).

Ports:
- clk  in  1  cam1_pclk
- resetn  in  1  asynchronous reset, active low
- vsync  in  1  vertical sync, polarity per VS_ACTIVE_HIGH
- de  in  1  data enable / href, high on active pixels
- pix  in  8  luma of current pixel, valid when de=1
- busy  in  1  logger busy
- new_sample  out  1  one-clk strobe to logger
- page  out  8  statistic index {5'b0, page_idx}
- value  out  16  statistic value

Behaviour:
- Reset (async, resetn=0):
  - new_sample=0, page=0, value=0.
  - All counters and accumulators = 0; min_acc=8'hFF, max_acc=0.
  - page_idx=0, div_cnt=0, armed=0, req=0, drop_cnt=0.
- Edge detection:
  - vs_act = vsync XNOR VS_ACTIVE_HIGH; vs_d and de_d are 1-clk registered copies.
  - frame_edge = vs_act & ~vs_d.
  - line_start = de & ~de_d & ~vs_act; line_end = ~de & de_d.
- Accumulate (only when de=1 and vs_act=0):
  - line_px++ (saturates at 16'hFFFF).
  - luma_sum += pix (32-bit, saturates).
  - min/max updated.
- Line tracking:
  - line_start: lines++ (saturates at 16'hFFFF); line_px cleared to 0, and the rising-edge pixel is counted as 1.
  - line_end: last_px <= line_px.
- Frame boundary (frame_edge):
  - If armed=0: set armed=1, clear accumulators, no snapshot. The partial first frame after reset is discarded.
  - If armed=1:
    - Snapshot into result regs: r0=frame_cnt+1 (16-bit wrap), r1=lines, r2=last_px, r3=sat16(luma_sum>>LUMA_SHIFT), r4={8'h0,max_acc}, r5={8'h0,min_acc}, r6=drop_cnt.
    - Clear accumulators; frame_cnt++.
    - div_cnt++; when div_cnt reaches FRAME_DIV-1 it wraps to 0 and sets req.
    - If req is already 1 at this point, drop_cnt++ (saturating 16-bit) and req stays 1; the newer snapshot overwrites the older one.
  - A pixel with de=1 while vs_act=1 is never counted.
- Emit state machine:
  - ST_IDLE → ST_EMIT when req=1 and busy=0.
  - ST_EMIT (1 clk): new_sample=1, page={5'b0,page_idx}, value=r[page_idx]; req cleared; page_idx = (page_idx==6)?0:page_idx+1. Then → ST_HOLD.
  - ST_HOLD: new_sample=0; wait for busy=1 or 4 clks elapsed (whichever first), then → ST_IDLE. This covers the logger's latency before asserting busy.
- Latency and output hold:
  - Earliest strobe is 1 clk after the frame_edge cycle, i.e. at the cycle following snapshot.
  - page/value hold their last emitted value between strobes.
- Simultaneous events:
  - frame_edge in the same cycle as ST_EMIT: the emit uses pre-edge results. The new req set by the edge wins over the clear.
  - req set while busy=1: strobe waits until busy=0.
- Frames with no active pixels report min=0xFF, max=0, lines=0, last_px=previous value.

Test Plan:
- Reset, FRAME_DIV=1, 3 frames of 4 lines × 10 px, pix=8'h40, busy=0 → no strobe for frame 1 (arming). Next two strobes: page=0 value=1, then page=1 value=4.
- Ramp pix 0..39 over 4×10 frame, FRAME_DIV=1, emit through 7 frames → page 2 value=10, page 4 value=0x0027, page 5 value=0x0000. Page 3 = sum 780>>LUMA_SHIFT (set 0 in test) = 780.
- FRAME_DIV=4, busy=0 → exactly one strobe per 4 frame edges after arming; page_idx wraps 6→0 on the 8th strobe.
- Hold busy=1 across 3 frame edges with FRAME_DIV=1 → no strobe while busy; after release one strobe. Later page 6 reports value=2 drops.
- Assert resetn=0 mid-line, mid-frame → outputs 0 immediately (async). The following frame edge only arms; no strobe until the second frame edge.
- de pulses during vsync blanking with pix=8'hFF → max stays at frame value, lines unchanged.

Source files
------------

// File: rtl/frame_stats_sampler.sv
// Per-frame camera stream statistics (frame/line counts, line length, luma sum, min/max, drops),
// presented one page at a time to the I2C frame logger as a single-cycle strobe.
module frame_stats_sampler #(
    parameter bit          VS_ACTIVE_HIGH = 1'b1,
    parameter int unsigned FRAME_DIV      = 4,
    parameter int unsigned LUMA_SHIFT     = 16,
    parameter int unsigned NUM_PAGES      = 7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        vsync,
    input  logic        de,
    input  logic [7:0]  pix,
    input  logic        busy,
    output logic        new_sample,
    output logic [7:0]  page,
    output logic [15:0] value
);

    typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_HOLD} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    hold_cnt_reg;

    logic          vs_d_reg, de_d_reg;
    logic [15:0]   line_px_reg, lines_reg, last_px_reg;
    logic [31:0]   luma_sum_reg;
    logic [7:0]    min_acc_reg, max_acc_reg;
    logic [15:0]   frame_cnt_reg, drop_cnt_reg;
    logic [7:0]    div_cnt_reg;
    logic          armed_reg, req_reg;
    logic [2:0]    page_idx_reg;
    logic [15:0]   res_reg [NUM_PAGES];
    logic [15:0]   snap_val [NUM_PAGES];
    logic [7:0]    page_hold_reg;
    logic [15:0]   value_hold_reg;

    logic          vs_act, frame_edge, line_start, line_end, px_valid;
    logic          snap_take, req_set, emit;
    logic [32:0]   luma_add;
    logic [31:0]   luma_next, luma_shifted;
    logic [15:0]   luma_page;

    assign vs_act     = (vsync == VS_ACTIVE_HIGH);
    assign frame_edge = vs_act & ~vs_d_reg;
    assign line_start = de & ~de_d_reg & ~vs_act;
    assign line_end   = ~de & de_d_reg;
    assign px_valid   = de & ~vs_act;

    assign snap_take  = frame_edge & armed_reg;
    assign req_set    = snap_take & (div_cnt_reg == 8'(FRAME_DIV - 1));
    assign emit       = (state_reg == ST_EMIT);

    assign luma_add     = {1'b0, luma_sum_reg} + {25'b0, pix};
    assign luma_next    = luma_add[32] ? 32'hFFFF_FFFF : luma_add[31:0];
    assign luma_shifted = luma_sum_reg >> LUMA_SHIFT;
    assign luma_page    = (|luma_shifted[31:16]) ? 16'hFFFF : luma_shifted[15:0];

    always_comb begin
        for (int i = 0; i < NUM_PAGES; i++) snap_val[i] = '0;
        snap_val[0] = frame_cnt_reg + 16'd1;
        snap_val[1] = lines_reg;
        snap_val[2] = last_px_reg;
        snap_val[3] = luma_page;
        snap_val[4] = {8'h00, max_acc_reg};
        snap_val[5] = {8'h00, min_acc_reg};
        snap_val[6] = drop_cnt_reg;
    end

    // line_px is a per-line counter, so it survives frame edges and blanking de pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vs_d_reg      <= 1'b0;
            de_d_reg      <= 1'b0;
            line_px_reg   <= '0;
            lines_reg     <= '0;
            last_px_reg   <= '0;
            luma_sum_reg  <= '0;
            min_acc_reg   <= 8'hFF;
            max_acc_reg   <= 8'h00;
            frame_cnt_reg <= '0;
            armed_reg     <= 1'b0;
        end else begin
            vs_d_reg <= vs_act;
            de_d_reg <= de;
            if (line_end)
                last_px_reg <= line_px_reg;
            if (frame_edge) begin
                lines_reg    <= '0;
                luma_sum_reg <= '0;
                min_acc_reg  <= 8'hFF;
                max_acc_reg  <= 8'h00;
                armed_reg    <= 1'b1;
                if (armed_reg)
                    frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end else if (px_valid) begin
                if (line_start) begin
                    line_px_reg <= 16'd1;
                    if (lines_reg != 16'hFFFF)
                        lines_reg <= lines_reg + 16'd1;
                end else if (line_px_reg != 16'hFFFF) begin
                    line_px_reg <= line_px_reg + 16'd1;
                end
                luma_sum_reg <= luma_next;
                if (pix < min_acc_reg) min_acc_reg <= pix;
                if (pix > max_acc_reg) max_acc_reg <= pix;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PAGES; i++) res_reg[i] <= '0;
        end else if (snap_take) begin
            for (int i = 0; i < NUM_PAGES; i++) res_reg[i] <= snap_val[i];
        end
    end

    // A new request wins over the clear done by a concurrent emit; overwriting an unconsumed one is a drop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt_reg  <= '0;
            req_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (snap_take)
                div_cnt_reg <= req_set ? 8'd0 : div_cnt_reg + 8'd1;
            if (req_set)
                req_reg <= 1'b1;
            else if (emit)
                req_reg <= 1'b0;
            if (req_set && req_reg && !emit && drop_cnt_reg != 16'hFFFF)
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            hold_cnt_reg   <= '0;
            page_idx_reg   <= '0;
            page_hold_reg  <= '0;
            value_hold_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= (state_reg == ST_HOLD) ? hold_cnt_reg + 2'd1 : 2'd0;
            if (emit) begin
                page_hold_reg  <= {5'b0, page_idx_reg};
                value_hold_reg <= res_reg[page_idx_reg];
                page_idx_reg   <= (page_idx_reg == 3'(NUM_PAGES - 1)) ? 3'd0 : page_idx_reg + 3'd1;
            end
        end
    end

    // Seeing req_set directly lets the strobe follow the frame edge by one clock
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if ((req_reg || req_set) && !busy) state_next = ST_EMIT;
            ST_EMIT: state_next = ST_HOLD;
            ST_HOLD: if (busy || hold_cnt_reg == 2'd3) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign new_sample = emit;
    assign page       = emit ? {5'b0, page_idx_reg} : page_hold_reg;
    assign value      = emit ? res_reg[page_idx_reg] : value_hold_reg;

endmodule

// File: tb/tb_frame_stats_sampler.sv
// Directed/randomized frame sequences checked against a frame-level statistics model.
module tb_frame_stats_sampler;

    localparam int FDIV = 2;
    localparam int LSH  = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        vsync = 1'b0;
    logic        de = 1'b0;
    logic [7:0]  pix = 8'h00;
    logic        busy = 1'b0;
    logic        new_sample;
    logic [7:0]  page;
    logic [15:0] value;

    always #5 clk = ~clk;

    frame_stats_sampler #(
        .VS_ACTIVE_HIGH(1'b1),
        .FRAME_DIV     (FDIV),
        .LUMA_SHIFT    (LSH),
        .NUM_PAGES     (7)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .vsync     (vsync),
        .de        (de),
        .pix       (pix),
        .busy      (busy),
        .new_sample(new_sample),
        .page      (page),
        .value     (value)
    );

    int tests = 0;
    int fails = 0;

    int got_page[$];
    int got_val[$];
    int exp_page[$];
    int exp_val[$];

    always @(negedge clk) begin
        if (new_sample === 1'b1) begin
            got_page.push_back(int'(page));
            got_val.push_back(int'(value));
        end
    end

    // frame-level model
    bit m_armed, m_req;
    int m_div, m_frames, m_drop, m_pidx;
    int m_snap[7];
    int a_lines, a_sum, a_min, a_max, a_last;

    function automatic void m_reset();
        m_armed = 0; m_req = 0; m_div = 0; m_frames = 0; m_drop = 0; m_pidx = 0;
        for (int i = 0; i < 7; i++) m_snap[i] = 0;
        a_lines = 0; a_sum = 0; a_min = 255; a_max = 0; a_last = 0;
        got_page.delete(); got_val.delete(); exp_page.delete(); exp_val.delete();
    endfunction

    function automatic void m_emit();
        if (m_req) begin
            exp_page.push_back(m_pidx);
            exp_val.push_back(m_snap[m_pidx]);
            m_pidx = (m_pidx + 1) % 7;
            m_req = 0;
        end
    endfunction

    function automatic void m_edge();
        int l;
        if (!m_armed) begin
            m_armed = 1;
        end else begin
            m_frames++;
            l = a_sum >> LSH;
            m_snap[0] = m_frames % 65536;
            m_snap[1] = a_lines;
            m_snap[2] = a_last;
            m_snap[3] = (l > 65535) ? 65535 : l;
            m_snap[4] = a_max;
            m_snap[5] = a_min;
            m_snap[6] = m_drop;
            m_div++;
            if (m_div == FDIV) begin
                m_div = 0;
                if (m_req && m_drop < 65535) m_drop++;
                m_req = 1;
            end
        end
        a_lines = 0; a_sum = 0; a_min = 255; a_max = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_strobes(input string tag);
        int n;
        chk({tag, "_count"}, got_page.size(), exp_page.size());
        n = (got_page.size() < exp_page.size()) ? got_page.size() : exp_page.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_page"}, got_page[i], exp_page[i]);
            chk({tag, "_value"}, got_val[i], exp_val[i]);
            $display("[TB] strobe page=%0d value=0x%04h expected page=%0d value=0x%04h",
                     got_page[i], got_val[i], exp_page[i], exp_val[i]);
        end
        got_page.delete(); got_val.delete(); exp_page.delete(); exp_val.delete();
    endtask

    // mode 0: constant 0x40, 1: ramp over the frame, 2: random with jittered line length
    task automatic run_frame(input int nl, input int np, input int mode, input bit b, input bit pulses);
        int idx, n;
        busy = b;
        if (!b) m_emit();
        repeat (8) tick();
        vsync = 1'b1;
        m_edge();
        if (!b) m_emit();
        for (int c = 0; c < 14; c++) begin
            de  = pulses && c >= 2 && c < 10 && (c % 4) < 2;
            pix = 8'hFF;
            tick();
        end
        de = 1'b0;
        check_strobes("blank");
        vsync = 1'b0;
        repeat (2) tick();
        idx = 0;
        for (int l = 0; l < nl; l++) begin
            n = (mode == 2) ? np + int'($urandom_range(0, 3)) : np;
            for (int p = 0; p < n; p++) begin
                de = 1'b1;
                case (mode)
                    0:       pix = 8'h40;
                    1:       pix = 8'(idx);
                    default: pix = 8'($urandom_range(0, 255));
                endcase
                a_sum += int'(pix);
                if (int'(pix) < a_min) a_min = int'(pix);
                if (int'(pix) > a_max) a_max = int'(pix);
                idx++;
                tick();
            end
            a_lines++;
            a_last = n;
            de = 1'b0;
            repeat (3) tick();
        end
    endtask

    initial begin
        m_reset();
        repeat (3) tick();
        chk("rst_new_sample", int'(new_sample), 0);
        chk("rst_page", int'(page), 0);
        chk("rst_value", int'(value), 0);
        resetn = 1'b1;
        tick();

        // constant frames: arming frame then first samples
        repeat (3) run_frame(4, 10, 0, 1'b0, 1'b0);
        // ramp frames
        repeat (5) run_frame(4, 10, 1, 1'b0, 1'b0);
        // empty frames and blanking de pulses
        run_frame(0, 0, 0, 1'b0, 1'b1);
        run_frame(0, 0, 0, 1'b0, 1'b0);
        run_frame(3, 7, 1, 1'b0, 1'b1);
        run_frame(2, 5, 2, 1'b0, 1'b1);
        for (int f = 0; f < 14; f++)
            run_frame(int'($urandom_range(0, 5)), int'($urandom_range(1, 12)), 2, 1'b0,
                      1'($urandom_range(0, 1)));
        // logger busy across several edges, then release
        repeat (5) run_frame(3, 6, 2, 1'b1, 1'b0);
        repeat (16) run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 9)), 2, 1'b0, 1'b0);

        // asynchronous reset in the middle of a line
        de = 1'b1;
        pix = 8'h11;
        repeat (3) tick();
        resetn = 1'b0;
        #1;
        chk("async_new_sample", int'(new_sample), 0);
        chk("async_page", int'(page), 0);
        chk("async_value", int'(value), 0);
        de = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        m_reset();
        tick();
        repeat (6) run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 9)), 2, 1'b0, 1'b0);
        repeat (8) tick();
        check_strobes("tail");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
